// File: rtl/data_memory_param.sv
// data_memory_param: parametrised single-port synchronous data memory.
// After reset a hardware sweep writes every word (mem[i] = i or 0, per
// INIT_MODE); requests are accepted only once the sweep finishes (ready=1).
// Reads have one-cycle latency; out-of-range writes are dropped and
// out-of-range reads return zero.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (out-of-range err pulse).
module data_memory_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 33,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic              ready,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              err
);

  // Array index width, and sweep counter width (one extra bit of headroom).
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     idx_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IW-1:0]     acc_idx;
  logic              accept;
  logic              sweep_last;
  logic              mem_we;
  logic [IW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Compare with one extra bit so DEPTH == 2**ADDR_W is handled.
  assign in_range = ({1'b0, address} < DEPTH_L);
  assign acc_idx  = address[IW-1:0];

  // Next-state logic: sweep in INIT, accept requests in IDLE.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    sweep_last = 1'b0;
    mem_we     = 1'b0;
    wr_addr    = acc_idx;
    wr_data    = dataIn;
    case (state)
      ST_INIT: begin
        mem_we   = 1'b1;
        wr_addr  = idx[IW-1:0];
        wr_data  = (INIT_MODE != 0) ? DATA_W'(idx) : '0;
        idx_next = idx + 1'b1;
        if (idx == LAST_IDX) begin
          sweep_last = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        accept = req;
        mem_we = req & we & in_range;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Storage array: sweep writes and accepted in-range writes.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered outputs: ready latch, read data and valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready     <= 1'b0;
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      if (sweep_last) begin
        ready <= 1'b1;
      end
      dataValid <= accept & ~we;
      if (accept && !we) begin
        dataOut <= in_range ? mem[acc_idx] : '0;
      end
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  // One-cycle pulse on any accepted request outside the implemented range.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= accept & ~in_range;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
